// File: rtl/convolve_pipelined.sv
// Two-stage pipelined 1-D convolution of a captured filter and signal.
// Stage 1 forms every tap product for one output index per cycle; stage 2
// sums them and writes the wrapped 16-bit result into that index's slot.
// `load` is both the synchronous reset and the input capture strobe.
module convolve_pipelined #(
  parameter int unsigned LEN             = 2,
  parameter int unsigned SIGNAL_LENGTH_1 = 4
) (
  input  logic                                      clk,
  input  logic                                      load,
  input  logic signed [(LEN+1)*16:0]                flaten_filter_coeff,
  input  logic signed [(SIGNAL_LENGTH_1+1)*16:0]    flaten_signal,
  output logic signed [(LEN+SIGNAL_LENGTH_1+1)*16:0] flatten_conv_result,
  output logic                                      is_completed
);

  localparam int unsigned Taps    = LEN + 1;
  localparam int unsigned Samples = SIGNAL_LENGTH_1 + 1;
  localparam int unsigned N       = LEN + SIGNAL_LENGTH_1 + 1;
  localparam int unsigned IdxW    = $clog2(N + 1);
  // Enough headroom that summing all products never loses precision.
  localparam int unsigned SumW    = 32 + $clog2(Taps) + 1;

  localparam logic [IdxW-1:0] NumOut = IdxW'(N);

  // Captured operands
  logic signed [15:0] coeff_q [Taps];
  logic signed [15:0] coeff_d [Taps];
  logic signed [15:0] sig_q   [Samples];
  logic signed [15:0] sig_d   [Samples];

  // Stage 1: issue counter and registered products
  logic [IdxW-1:0]    issue_q, issue_d;
  logic               s1_valid_q, s1_valid_d;
  logic [IdxW-1:0]    s1_idx_q, s1_idx_d;
  logic signed [31:0] prod_q [Taps];
  logic signed [31:0] prod_d [Taps];

  // Stage 2: result slots and completion
  logic [N-1:0][15:0] result_q, result_d;
  logic               done_q, done_d;

  // The top bit of each flattened input carries no data.
  logic unused_top;
  assign unused_top = flaten_filter_coeff[Taps*16] ^ flaten_signal[Samples*16];

  // Next-state for capture, both pipeline stages and completion.
  always_comb begin
    logic signed [15:0]     x_sel;
    logic signed [SumW-1:0] sum;

    coeff_d    = coeff_q;
    sig_d      = sig_q;
    issue_d    = issue_q;
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    prod_d     = prod_q;
    result_d   = result_q;
    done_d     = done_q;
    x_sel      = '0;
    sum        = '0;

    if (load) begin
      for (int k = 0; k < Taps; k++) begin
        coeff_d[k] = flaten_filter_coeff[k*16 +: 16];
      end
      for (int j = 0; j < Samples; j++) begin
        sig_d[j] = flaten_signal[j*16 +: 16];
      end
      issue_d    = '0;
      s1_valid_d = 1'b0;
      s1_idx_d   = '0;
      result_d   = '0;
      done_d     = 1'b0;
    end else begin
      // Stage 1: products for output index issue_q; out-of-range samples are zero.
      if (issue_q < NumOut) begin
        for (int k = 0; k < Taps; k++) begin
          x_sel = '0;
          for (int j = 0; j < Samples; j++) begin
            if (int'(issue_q) == j + k) begin
              x_sel = sig_q[j];
            end
          end
          prod_d[k] = coeff_q[k] * x_sel;
        end
        s1_valid_d = 1'b1;
        s1_idx_d   = issue_q;
        issue_d    = issue_q + IdxW'(1);
      end else begin
        s1_valid_d = 1'b0;
      end

      // Stage 2: full-precision sum, low 16 bits kept.
      if (s1_valid_q) begin
        for (int k = 0; k < Taps; k++) begin
          sum = sum + SumW'(prod_q[k]);
        end
        for (int n = 0; n < N; n++) begin
          if (s1_idx_q == IdxW'(n)) begin
            result_d[n] = sum[15:0];
          end
        end
      end

      // Every index issued and the last one written back: pipeline is drained.
      if (issue_q == NumOut && !s1_valid_q) begin
        done_d = 1'b1;
      end
    end
  end

  // State registers; load acts as the synchronous reset.
  always_ff @(posedge clk) begin
    coeff_q    <= coeff_d;
    sig_q      <= sig_d;
    issue_q    <= issue_d;
    s1_valid_q <= s1_valid_d;
    s1_idx_q   <= s1_idx_d;
    prod_q     <= prod_d;
    result_q   <= result_d;
    done_q     <= done_d;
  end

  assign flatten_conv_result = {1'b0, result_q};
  assign is_completed        = done_q;

endmodule

// File: tb/tb_convolve_pipelined.sv
// Randomized and directed bench for convolve_pipelined against a plain
// arithmetic convolution model, checked every cycle of every run.
module tb_convolve_pipelined;

  localparam int LEN  = 2;
  localparam int SL1  = 4;
  localparam int TAPS = LEN + 1;
  localparam int SAMP = SL1 + 1;
  localparam int N    = LEN + SL1 + 1;
  localparam int CW   = TAPS * 16 + 1;
  localparam int SW   = SAMP * 16 + 1;
  localparam int RW   = N * 16 + 1;

  logic          clk = 1'b0;
  logic          load;
  logic [CW-1:0] coeff;
  logic [SW-1:0] sig;
  logic [RW-1:0] res;
  logic          done;

  int            checks = 0;
  int            errors = 0;
  int            h [TAPS];
  int            x [SAMP];
  logic [RW-1:0] y_exp;

  always #5 clk = ~clk;

  convolve_pipelined #(
    .LEN             (LEN),
    .SIGNAL_LENGTH_1 (SL1)
  ) dut (
    .clk                 (clk),
    .load                (load),
    .flaten_filter_coeff (coeff),
    .flaten_signal       (sig),
    .flatten_conv_result (res),
    .is_completed        (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Direct-form convolution with wide integers, then wrapped to 16 bits.
  task automatic model();
    longint acc;
    logic [63:0] acc_bits;
    y_exp = '0;
    for (int n = 0; n < N; n++) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++) begin
        if (n - k >= 0 && n - k < SAMP) acc += longint'(h[k]) * longint'(x[n - k]);
      end
      acc_bits = acc;
      y_exp[n*16 +: 16] = acc_bits[15:0];
    end
  endtask

  task automatic drive_real();
    logic [31:0] r;
    for (int k = 0; k < TAPS; k++) begin
      r = h[k];
      coeff[k*16 +: 16] = r[15:0];
    end
    for (int j = 0; j < SAMP; j++) begin
      r = x[j];
      sig[j*16 +: 16] = r[15:0];
    end
    coeff[CW-1] = 1'($urandom);
    sig[SW-1]   = 1'($urandom);
  endtask

  task automatic drive_junk();
    for (int k = 0; k < TAPS; k++) coeff[k*16 +: 16] = 16'($urandom);
    for (int j = 0; j < SAMP; j++) sig[j*16 +: 16] = 16'($urandom);
    coeff[CW-1] = 1'($urandom);
    sig[SW-1]   = 1'($urandom);
  endtask

  // Hold load for `hold` edges; only the last edge sees the real operands.
  task automatic start(input int hold);
    for (int c = 0; c < hold; c++) begin
      if (c == hold - 1) drive_real();
      else drive_junk();
      load = 1'b1;
      @(negedge clk);
      check($sformatf("load%0d_res", c), 128'(res), 128'(0));
      check($sformatf("load%0d_done", c), 128'(done), 128'(0));
    end
    load = 1'b0;
    drive_junk();
  endtask

  // After edge e, slots 0..e-2 are final, the rest zero; done from edge N+2.
  task automatic run(input int edges);
    logic [RW-1:0] exp_r;
    for (int e = 1; e <= edges; e++) begin
      @(negedge clk);
      drive_junk();
      exp_r = '0;
      for (int n = 0; n < N; n++) begin
        if (n <= e - 2) exp_r[n*16 +: 16] = y_exp[n*16 +: 16];
      end
      check($sformatf("edge%0d_res", e), 128'(res), 128'(exp_r));
      check($sformatf("edge%0d_done", e), 128'(done), 128'(e >= N + 2));
    end
  endtask

  task automatic set_hx(input int h0, input int h1, input int h2, input int x0,
                        input int x1, input int x2, input int x3, input int x4);
    h[0] = h0; h[1] = h1; h[2] = h2;
    x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3; x[4] = x4;
    model();
  endtask

  initial begin
    logic signed [15:0] r16;
    load  = 1'b0;
    coeff = '0;
    sig   = '0;

    set_hx(1, 2, 3, 1, 1, 1, 1, 1);
    start(2);
    run(N + 4);

    set_hx(-1, 0, 1, 1, 2, 3, 4, 5);
    start(1);
    run(N + 3);

    set_hx(1, 0, 0, 10, 20, 30, 40, 50);
    start(1);
    run(N + 3);

    set_hx(32767, 0, 0, 2, 0, 0, 0, 0);
    start(1);
    run(N + 3);

    // Abort a run four edges in, then restart with new operands.
    set_hx(1, 2, 3, 1, 1, 1, 1, 1);
    start(1);
    run(4);
    set_hx(1, 0, 0, 1, 2, 3, 4, 5);
    start(1);
    run(N + 3);

    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < TAPS; k++) begin
        r16 = 16'($urandom);
        h[k] = r16;
      end
      for (int j = 0; j < SAMP; j++) begin
        r16 = 16'($urandom);
        x[j] = r16;
      end
      model();
      start(int'($urandom_range(1, 3)));
      run(int'($urandom_range(N + 2, N + 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
